// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the data-memory requester: access sizes, FSM states,
// default address width and the size-alignment helper.
package riscv_mem_pkg;

    localparam int DEFAULT_ADDR_W = 48;

    // Access size as carried on req_size: the operand is (1 << size) bytes.
    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR      = 2'd2,
        RESP    = 2'd3
    } state_e;

    // An access is misaligned when its byte offset is not a multiple of its size.
    function automatic logic is_misaligned(input logic [2:0] offset, input size_e size);
        logic result;
        case (size)
            SZ_B:    result = 1'b0;
            SZ_H:    result = offset[0];
            SZ_W:    result = |offset[1:0];
            default: result = |offset;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/lane_merge_extract.sv
// Byte-lane datapath: merges store data into an old doubleword and extracts
// (with sign or zero extension) a load operand from a doubleword.
module lane_merge_extract
    import riscv_mem_pkg::*;
(
    input  logic [63:0] merge_old,
    input  logic [63:0] merge_new,
    input  logic [63:0] extract_src,
    input  logic [2:0]  offset,
    input  size_e       size,
    input  logic        is_unsigned,
    output logic [63:0] merged,
    output logic [63:0] extracted
);

    logic [63:0] new_shifted;
    logic [63:0] src_shifted;
    logic [3:0]  lane_count;

    // Right-justified store data moved up to its byte lane; only the
    // selected lanes are taken from it, so the upper bits are don't-care.
    assign new_shifted = merge_new << {offset, 3'b000};
    assign src_shifted = extract_src >> {offset, 3'b000};
    assign lane_count  = 4'd1 << size;

    // Per byte: replace when the byte lies in [offset, offset + bytes).
    // The 4-bit difference wraps to >= 9 for bytes below offset, so a single
    // unsigned compare covers both bounds.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            logic [3:0] rel_idx;
            assign rel_idx = 4'(gi) - {1'b0, offset};
            assign merged[8*gi +: 8] = (rel_idx < lane_count) ? new_shifted[8*gi +: 8]
                                                               : merge_old[8*gi +: 8];
        end
    endgenerate

    // Load extract: operand is already at bit 0, extend from its top bit.
    always_comb begin
        extracted = src_shifted;
        case (size)
            SZ_B:    extracted = {{56{!is_unsigned && src_shifted[7]}},  src_shifted[7:0]};
            SZ_H:    extracted = {{48{!is_unsigned && src_shifted[15]}}, src_shifted[15:0]};
            SZ_W:    extracted = {{32{!is_unsigned && src_shifted[31]}}, src_shifted[31:0]};
            default: extracted = src_shifted;
        endcase
    end

endmodule

// File: rtl/data_memory_requester.sv
// Initiator toward data_memory: turns one byte/half/word/doubleword request at
// a time into doubleword-aligned memRead/memWrite transactions, using
// read-modify-write for partial stores, and returns extended load data.
module data_memory_requester
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W       = DEFAULT_ADDR_W,
    parameter int DATA_W       = 64,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_misaligned,
    output logic              memWrite,
    output logic              memRead,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] writeData,
    input  logic [DATA_W-1:0] readData
);

    state_e              state_reg;
    state_e              state_next;
    logic                accept;
    logic                req_misaligned;

    logic                write_reg;
    size_e               size_reg;
    logic                unsigned_reg;
    logic                misaligned_reg;
    logic [2:0]          offset_reg;
    logic [1:0]          cnt_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [DATA_W-1:0]   rdbuf_reg;
    logic [DATA_W-1:0]   write_data_reg;
    logic [ADDR_W-1:0]   address_reg;

    logic [63:0]         merged;
    logic [63:0]         extracted;

    assign accept         = req_valid && (state_reg == IDLE);
    assign req_misaligned = is_misaligned(req_addr[2:0], size_e'(req_size));

    lane_merge_extract u_lanes (
        .merge_old   (readData),
        .merge_new   (wdata_reg),
        .extract_src (rdbuf_reg),
        .offset      (offset_reg),
        .size        (size_reg),
        .is_unsigned (unsigned_reg),
        .merged      (merged),
        .extracted   (extracted)
    );

    // State register; reset aborts any in-flight access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        state_next = state_reg;
        req_ready  = 1'b0;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        resp_valid = 1'b0;
        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_misaligned) begin
                        state_next = RESP;
                    end else if (!req_write || (size_e'(req_size) != SZ_D)) begin
                        state_next = RD_WAIT;
                    end else begin
                        state_next = WR;
                    end
                end
            end
            RD_WAIT: begin
                memRead = 1'b1;
                if (cnt_reg == 2'd0) begin
                    state_next = write_reg ? WR : RESP;
                end
            end
            WR: begin
                memWrite   = 1'b1;
                state_next = RESP;
            end
            default: begin
                resp_valid = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    // Request capture, read-latency countdown and write-data formation.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_reg      <= 1'b0;
            size_reg       <= SZ_B;
            unsigned_reg   <= 1'b0;
            misaligned_reg <= 1'b0;
            offset_reg     <= '0;
            cnt_reg        <= '0;
            wdata_reg      <= '0;
            rdbuf_reg      <= '0;
            write_data_reg <= '0;
            address_reg    <= '0;
        end else begin
            if (accept) begin
                write_reg      <= req_write;
                size_reg       <= size_e'(req_size);
                unsigned_reg   <= req_unsigned;
                misaligned_reg <= req_misaligned;
                offset_reg     <= req_addr[2:0];
                wdata_reg      <= req_wdata;
                cnt_reg        <= 2'(READ_LATENCY);
                // A misaligned request never touches memory, so the bus keeps its old address.
                if (!req_misaligned) begin
                    address_reg <= {req_addr[ADDR_W-1:3], 3'b000};
                end
                // Full doubleword stores skip the read and write the data as-is.
                if (!req_misaligned && req_write && (size_e'(req_size) == SZ_D)) begin
                    write_data_reg <= req_wdata;
                end
            end
            if (state_reg == RD_WAIT) begin
                if (cnt_reg == 2'd0) begin
                    rdbuf_reg <= readData;
                    if (write_reg) begin
                        write_data_reg <= merged;
                    end
                end else begin
                    cnt_reg <= cnt_reg - 2'd1;
                end
            end
        end
    end

    assign address         = address_reg;
    assign writeData       = write_data_reg;
    assign resp_misaligned = (state_reg == RESP) && misaligned_reg;
    assign resp_rdata      = ((state_reg == RESP) && !write_reg && !misaligned_reg) ? extracted : '0;

endmodule

// File: tb/tb_data_memory_requester.sv
// Testbench for data_memory_requester: directed scenarios plus randomized
// traffic against a byte-array reference model, with a scoreboard monitor.
module tb_data_memory_requester;

    localparam int AW = 48;
    localparam int RL = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [AW-1:0] req_addr;
    logic [63:0]   req_wdata;
    logic          resp_valid;
    logic [63:0]   resp_rdata;
    logic          resp_misaligned;
    logic          memWrite;
    logic          memRead;
    logic [AW-1:0] address;
    logic [63:0]   writeData;
    logic [63:0]   readData;

    always #5 clk = ~clk;

    data_memory_requester #(
        .ADDR_W       (AW),
        .DATA_W       (64),
        .READ_LATENCY (RL)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_size        (req_size),
        .req_unsigned    (req_unsigned),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_misaligned (resp_misaligned),
        .memWrite        (memWrite),
        .memRead         (memRead),
        .address         (address),
        .writeData       (writeData),
        .readData        (readData)
    );

    // Memory seen by the DUT (512 bytes, registered read = latency 1) and the
    // reference view of the same storage as a flat byte array.
    logic [63:0] mem [0:63];
    logic [7:0]  ref_bytes [0:511];

    typedef struct {
        logic [63:0] rdata;
        bit          mis;
        int          lat;
        int          acc;
        logic [47:0] addr;
        bit          wr;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int failures = 0;
    int cycle = 0;
    int wr_count = 0;
    int rd_count = 0;
    int resp_count = 0;
    logic [AW-1:0] last_wr_addr = '0;
    logic [63:0]   last_wr_data = '0;

    always @(posedge clk) cycle <= cycle + 1;

    initial begin : memory_model
        readData = '0;
        forever begin
            @(posedge clk);
            if (memWrite) mem[address[8:3]] = writeData;
            if (memRead) readData <= mem[address[8:3]];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_load(input int addr, input int sz, input bit uns);
        int n;
        logic [63:0] v;
        n = 1 << sz;
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_bytes[addr + i];
        if (!uns && n < 8 && v[8*n-1]) begin
            for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
        end
        return v;
    endfunction

    // Monitor: bus sanity, write/read bookkeeping and scoreboard compare.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (memRead === 1'b1 || memWrite === 1'b1) begin
                check("strobe_exclusive", 64'(memRead & memWrite), 64'd0);
                check("bus_addr_aligned", 64'(address[2:0]), 64'd0);
            end
            if (memWrite === 1'b1) begin
                wr_count++;
                last_wr_addr = address;
                last_wr_data = writeData;
            end
            if (memRead === 1'b1) rd_count++;
            if (resp_valid === 1'b1) begin
                resp_count++;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_resp: got resp_valid rdata=%h, required no response", resp_rdata);
                end else begin
                    e = sb.pop_front();
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("resp_misaligned", 64'(resp_misaligned), 64'(e.mis));
                    check("resp_latency", 64'(cycle - e.acc + 1), 64'(e.lat));
                    $display("resp %0d: %s addr=%h rdata=%h misaligned=%0b latency=%0d",
                             resp_count, e.wr ? "store" : "load", e.addr, resp_rdata,
                             resp_misaligned, cycle - e.acc + 1);
                end
            end
        end
    end

    // Issue one request (called right after a negedge); pushes the expected
    // response and updates the reference model when tracked.
    task automatic send(input bit wr, input logic [1:0] sz, input bit uns, input logic [47:0] addr,
                        input logic [63:0] wd, input bit hold, input bit track);
        exp_t e;
        int guard;
        int n;
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        guard = 0;
        while (req_ready !== 1'b1) begin
            @(negedge clk);
            guard++;
            if (guard > 200) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout: req_ready=%b, required 1", req_ready);
                req_valid = 1'b0;
                return;
            end
        end
        n      = 1 << sz;
        e.acc  = cycle + 1;
        e.addr = addr;
        e.wr   = wr;
        if ((int'(addr) % n) != 0) begin
            e.mis = 1'b1; e.rdata = '0; e.lat = 1;
        end else if (wr) begin
            e.mis = 1'b0; e.rdata = '0;
            e.lat = (sz == 2'd3) ? 2 : RL + 3;
            if (track) for (int i = 0; i < n; i++) ref_bytes[int'(addr) + i] = wd[8*i +: 8];
        end else begin
            e.mis = 1'b0;
            e.rdata = ref_load(int'(addr), int'(sz), uns);
            e.lat = RL + 2;
        end
        if (track) sb.push_back(e);
        @(negedge clk);
        check("ready_low_when_busy", 64'(req_ready), 64'd0);
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int wrb;
        int rdb;
        int rcb;
        logic [63:0] w;
        logic [1:0] sz;
        int addr;
        bit hold;

        rst = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_size = 2'd0;
        req_unsigned = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        for (int i = 0; i < 64; i++) begin
            w = {$urandom, $urandom};
            mem[i] = w;
            for (int b = 0; b < 8; b++) ref_bytes[i*8 + b] = w[8*b +: 8];
        end

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_mem_strobes", 64'({memRead, memWrite}), 64'd0);
        check("rst_address", 64'(address), 64'd0);
        check("rst_writeData", writeData, 64'd0);
        check("rst_resp_rdata", resp_rdata, 64'd0);
        check("rst_resp_misaligned", 64'(resp_misaligned), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Doubleword store then load.
        wrb = wr_count;
        send(1'b1, 2'd3, 1'b0, 48'h40, 64'h0123456789ABCDEF, 1'b0, 1'b1);
        drain();
        check("dw_store_write_pulses", 64'(wr_count - wrb), 64'd1);
        check("dw_store_address", 64'(last_wr_addr), 64'h40);
        check("dw_store_writeData", last_wr_data, 64'h0123456789ABCDEF);
        send(1'b0, 2'd3, 1'b0, 48'h40, 64'd0, 1'b0, 1'b1);
        drain();

        // Byte store read-modify-write (junk in upper store bits must be ignored).
        wrb = wr_count;
        rdb = rd_count;
        send(1'b1, 2'd0, 1'b0, 48'h43, 64'h5555_5555_5555_55AA, 1'b0, 1'b1);
        drain();
        check("rmw_read_cycles", 64'(rd_count - rdb), 64'(RL + 1));
        check("rmw_write_pulses", 64'(wr_count - wrb), 64'd1);
        check("rmw_writeData", last_wr_data, 64'h01234567AAABCDEF);

        // Sign vs zero extension.
        send(1'b0, 2'd0, 1'b0, 48'h43, 64'd0, 1'b0, 1'b1);
        send(1'b0, 2'd0, 1'b1, 48'h43, 64'd0, 1'b0, 1'b1);
        send(1'b0, 2'd1, 1'b0, 48'h46, 64'd0, 1'b0, 1'b1);
        drain();

        // Misaligned word load: no memory access at all.
        wrb = wr_count;
        rdb = rd_count;
        send(1'b0, 2'd2, 1'b0, 48'h42, 64'd0, 1'b0, 1'b1);
        drain();
        check("misaligned_no_access", 64'((rd_count - rdb) + (wr_count - wrb)), 64'd0);

        // Reset during the read phase of a byte store to 0x48.
        wrb = wr_count;
        rcb = resp_count;
        send(1'b1, 2'd0, 1'b0, 48'h48, 64'h77, 1'b0, 1'b0);
        check("abort_in_read_phase", 64'(memRead), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready_after_reset", 64'(req_ready), 64'd1);
        repeat (6) @(negedge clk);
        check("abort_no_write", 64'(wr_count - wrb), 64'd0);
        check("abort_no_resp", 64'(resp_count - rcb), 64'd0);
        send(1'b0, 2'd3, 1'b0, 48'h48, 64'd0, 1'b0, 1'b1);
        drain();

        // Back-to-back loads with req_valid held high.
        rcb = resp_count;
        send(1'b0, 2'd3, 1'b0, 48'h00, 64'd0, 1'b1, 1'b1);
        send(1'b0, 2'd3, 1'b0, 48'h08, 64'd0, 1'b1, 1'b1);
        send(1'b0, 2'd3, 1'b0, 48'h10, 64'd0, 1'b1, 1'b1);
        send(1'b0, 2'd3, 1'b0, 48'h18, 64'd0, 1'b0, 1'b1);
        drain();
        check("b2b_resp_count", 64'(resp_count - rcb), 64'd4);

        // Randomized traffic against the reference model.
        for (int k = 0; k < 200; k++) begin
            sz = 2'($urandom_range(0, 3));
            addr = int'($urandom_range(0, 511));
            if ($urandom_range(0, 3) != 0) addr = addr & ~((1 << sz) - 1);
            hold = ($urandom_range(0, 2) != 0);
            send(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), 48'(addr),
                 {$urandom, $urandom}, hold, 1'b1);
            if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        req_valid = 1'b0;
        drain();

        // Final memory image must match the reference byte array.
        for (int i = 0; i < 64; i++) begin
            for (int b = 0; b < 8; b++) w[8*b +: 8] = ref_bytes[i*8 + b];
            check($sformatf("mem_word_%0d", i), mem[i], w);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
